// File: rtl/collision_scanner_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | collision_scanner_if                                                 |
// | Bitmap read bus: address/strobe out, reference + object pixels back. |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
interface collision_scanner_if #(
  parameter int X_W    = 8,
  parameter int Y_W    = 7,
  parameter int NUM_CH = 16
);
  logic              rd_en;
  logic [X_W-1:0]    rd_x;
  logic [Y_W-1:0]    rd_y;
  logic              ref_pix;
  logic [NUM_CH-1:0] ch_pix;

  modport master (output rd_en, rd_x, rd_y, input ref_pix, ch_pix);
  modport slave  (input rd_en, rd_x, rd_y, output ref_pix, ch_pix);
endinterface
`default_nettype wire

// File: rtl/collision_scanner.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | collision_scanner                                                    |
// | Per-frame raster overlap test of a reference layer vs NUM_CH layers. |
// | Option macro: COLLISION_EARLY_EXIT_EN (stop at the first hit pixel). |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module collision_scanner #(
  parameter int H_RES  = 160,
  parameter int V_RES  = 120,
  parameter int X_W    = 8,
  parameter int Y_W    = 7,
  parameter int NUM_CH = 16,
  parameter int CH_W   = 4
) (
  input  wire                  clock,
  input  wire                  reset,
  input  wire                  start,
  input  wire                  abort,
  input  wire [NUM_CH-1:0]     ch_en,
  collision_scanner_if.master  mem,
  output logic                 busy,
  output logic                 done,
  output logic                 hit_any,
  output logic [NUM_CH-1:0]    hit_mask,
  output logic [X_W-1:0]       first_x,
  output logic [Y_W-1:0]       first_y,
  output logic [CH_W-1:0]      first_ch
);

`ifdef COLLISION_EARLY_EXIT_EN
  localparam logic c_EARLY_EXIT = 1'b1;
`else
  localparam logic c_EARLY_EXIT = 1'b0;
`endif

  localparam logic [X_W-1:0] c_X_LAST = X_W'(H_RES - 1);
  localparam logic [Y_W-1:0] c_Y_LAST = Y_W'(V_RES - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SCAN  = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [X_W-1:0]    r_x;
  logic [Y_W-1:0]    r_y;
  logic              r_cmp_valid;
  logic [X_W-1:0]    r_cmp_x;
  logic [Y_W-1:0]    r_cmp_y;
  logic [NUM_CH-1:0] r_ch_en;
  logic [NUM_CH-1:0] r_hit_mask;
  logic              r_hit_any;
  logic [X_W-1:0]    r_first_x;
  logic [Y_W-1:0]    r_first_y;
  logic [CH_W-1:0]   r_first_ch;
  logic [NUM_CH-1:0] w_hit;
  logic              w_first_hit;
  logic              w_last_addr;
  logic [CH_W-1:0]   w_hit_ch;

  assign w_last_addr = (r_x == c_X_LAST) && (r_y == c_Y_LAST);

  // Compare stage sees data for the address issued one cycle earlier.
  assign w_hit       = r_cmp_valid ? (mem.ch_pix & r_ch_en & {NUM_CH{mem.ref_pix}})
                                   : '0;
  assign w_first_hit = (|w_hit) && !r_hit_any;

  always_comb begin
    w_hit_ch = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (w_hit[i]) w_hit_ch = CH_W'(i);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = S_SCAN;
      S_SCAN: begin
        if (abort)                            w_next = S_IDLE;
        else if (c_EARLY_EXIT && w_first_hit) w_next = S_DONE;
        else if (w_last_addr)                 w_next = S_DRAIN;
      end
      S_DRAIN: begin
        if (abort) w_next = S_IDLE;
        else       w_next = S_DONE;
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Address counters sit at zero whenever the scan is not continuing.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_x <= '0;
      r_y <= '0;
    end else if (r_state == S_SCAN && w_next == S_SCAN) begin
      if (r_x == c_X_LAST) begin
        r_x <= '0;
        r_y <= r_y + 1'b1;
      end else begin
        r_x <= r_x + 1'b1;
      end
    end else begin
      r_x <= '0;
      r_y <= '0;
    end
  end

  // A read whose scan is being abandoned never reaches the compare stage.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_cmp_valid <= 1'b0;
      r_cmp_x     <= '0;
      r_cmp_y     <= '0;
    end else begin
      r_cmp_valid <= (r_state == S_SCAN) && (w_next == S_SCAN || w_next == S_DRAIN);
      r_cmp_x     <= r_x;
      r_cmp_y     <= r_y;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_ch_en    <= '0;
      r_hit_mask <= '0;
      r_hit_any  <= 1'b0;
      r_first_x  <= '0;
      r_first_y  <= '0;
      r_first_ch <= '0;
    end else if (r_state == S_IDLE && start) begin
      r_ch_en    <= ch_en;
      r_hit_mask <= '0;
      r_hit_any  <= 1'b0;
      r_first_x  <= '0;
      r_first_y  <= '0;
      r_first_ch <= '0;
    end else if ((r_state == S_SCAN || r_state == S_DRAIN) && abort) begin
      r_hit_mask <= '0;
      r_hit_any  <= 1'b0;
      r_first_x  <= '0;
      r_first_y  <= '0;
      r_first_ch <= '0;
    end else if (|w_hit) begin
      r_hit_mask <= r_hit_mask | w_hit;
      r_hit_any  <= 1'b1;
      if (w_first_hit) begin
        r_first_x  <= r_cmp_x;
        r_first_y  <= r_cmp_y;
        r_first_ch <= w_hit_ch;
      end
    end
  end

  assign mem.rd_en = (r_state == S_SCAN);
  assign mem.rd_x  = r_x;
  assign mem.rd_y  = r_y;
  assign busy      = (r_state == S_SCAN) || (r_state == S_DRAIN);
  assign done      = (r_state == S_DONE);
  assign hit_any   = r_hit_any;
  assign hit_mask  = r_hit_mask;
  assign first_x   = r_first_x;
  assign first_y   = r_first_y;
  assign first_ch  = r_first_ch;

endmodule
`default_nettype wire

// File: tb/tb_collision_scanner.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_collision_scanner                                                 |
// | Directed vector bench with a sparse bitmap memory model.             |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_collision_scanner;

`ifdef COLLISION_EARLY_EXIT_EN
  localparam bit EE = 1'b1;
`else
  localparam bit EE = 1'b0;
`endif

  typedef struct packed {
    logic [7:0]  x;
    logic [6:0]  y;
    logic        r;
    logic [15:0] ch;
  } pix_t;

  typedef struct packed {
    logic [15:0] ch_en;
    pix_t        p0;
    pix_t        p1;
    pix_t        p2;
    int          pulse_at;
    logic [15:0] exp_mask;
    logic [7:0]  ex;
    logic [6:0]  ey;
    logic [3:0]  ec;
    int          exp_lat;
    int          exp_rd;
  } vec_t;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [15:0] ch_en = '1;
  logic        busy, done, hit_any;
  logic [15:0] hit_mask;
  logic [7:0]  first_x;
  logic [6:0]  first_y;
  logic [3:0]  first_ch;

  int   n_checks = 0;
  int   n_fail   = 0;
  pix_t tab[3];
  vec_t vecs[3];

  collision_scanner_if #(.X_W(8), .Y_W(7), .NUM_CH(16)) mem ();

  collision_scanner #(
    .H_RES(160), .V_RES(120), .X_W(8), .Y_W(7), .NUM_CH(16), .CH_W(4)
  ) dut (
    .clock(clock), .reset(reset), .start(start), .abort(abort), .ch_en(ch_en),
    .mem(mem), .busy(busy), .done(done), .hit_any(hit_any), .hit_mask(hit_mask),
    .first_x(first_x), .first_y(first_y), .first_ch(first_ch)
  );

  always #5 clock = ~clock;

  // One-cycle-latency memory; returns all ones when not read.
  always @(posedge clock) begin : mem_model
    logic        r;
    logic [15:0] c;
    r = 1'b0;
    c = '0;
    for (int k = 0; k < 3; k++) begin
      if (tab[k].x == mem.rd_x && tab[k].y == mem.rd_y) begin
        r = r | tab[k].r;
        c = c | tab[k].ch;
      end
    end
    if (mem.rd_en) begin
      mem.ref_pix <= r;
      mem.ch_pix  <= c;
    end else begin
      mem.ref_pix <= 1'b1;
      mem.ch_pix  <= '1;
    end
  end

  function automatic pix_t mk_pix(input int x, input int y, input logic r, input logic [15:0] ch);
    pix_t p;
    p.x  = 8'(x);
    p.y  = 7'(y);
    p.r  = r;
    p.ch = ch;
    return p;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Call at #1 after a rising edge; returns at the falling edge of the done cycle.
  task automatic run_frame(input logic with_abort, input int pulse_at, output int lat, output int rdn);
    lat   = -1;
    rdn   = 0;
    start = 1'b1;
    abort = with_abort;
    @(posedge clock); #1;
    start = 1'b0;
    abort = 1'b0;
    for (int n = 1; n <= 19400; n++) begin
      start = (n == pulse_at);
      if (n == pulse_at) ch_en = ~ch_en;
      @(negedge clock);
      if (mem.rd_en) rdn++;
      if (done) begin
        lat = n;
        break;
      end
      @(posedge clock); #1;
    end
    start = 1'b0;
  endtask

  initial begin : main
    int lat, rdn;
    logic seen_done;

    for (int k = 0; k < 3; k++) tab[k] = '0;

    repeat (3) @(posedge clock);
    @(negedge clock);
    check("rst_rd_en",    32'(mem.rd_en), 32'd0);
    check("rst_rd_x",     32'(mem.rd_x),  32'd0);
    check("rst_busy",     32'(busy),      32'd0);
    check("rst_done",     32'(done),      32'd0);
    check("rst_hit_any",  32'(hit_any),   32'd0);
    check("rst_hit_mask", 32'(hit_mask),  32'd0);
    check("rst_first_x",  32'(first_x),   32'd0);
    check("rst_first_ch", 32'(first_ch),  32'd0);
    reset = 1'b0;
    @(posedge clock); #1;

    vecs[0] = '{16'hFFFF, mk_pix(5, 2, 1'b1, 16'h0008), mk_pix(7, 2, 1'b0, 16'h0020), '0,
                0, 16'h0008, 8'd5, 7'd2, 4'd3, EE ? 328 : 19202, EE ? 327 : 19200};
    vecs[1] = '{16'hFFFF, mk_pix(159, 119, 1'b1, 16'h0081), mk_pix(0, 0, 1'b1, 16'h0000), '0,
                0, 16'h0081, 8'd159, 7'd119, 4'd0, 19202, 19200};
    vecs[2] = '{16'hFDFF, mk_pix(10, 0, 1'b1, 16'h0004), mk_pix(0, 1, 1'b1, 16'h0200), '0,
                50, 16'h0004, 8'd10, 7'd0, 4'd2, EE ? 13 : 19202, EE ? 12 : 19200};

    foreach (vecs[i]) begin
      tab[0] = vecs[i].p0;
      tab[1] = vecs[i].p1;
      tab[2] = vecs[i].p2;
      ch_en  = vecs[i].ch_en;
      run_frame(1'b0, vecs[i].pulse_at, lat, rdn);
      check($sformatf("v%0d_latency", i),  32'(lat),      32'(vecs[i].exp_lat));
      check($sformatf("v%0d_rd_count", i), 32'(rdn),      32'(vecs[i].exp_rd));
      check($sformatf("v%0d_hit_mask", i), 32'(hit_mask), 32'(vecs[i].exp_mask));
      check($sformatf("v%0d_hit_any", i),  32'(hit_any),  32'(vecs[i].exp_mask != 0));
      check($sformatf("v%0d_first_x", i),  32'(first_x),  32'(vecs[i].ex));
      check($sformatf("v%0d_first_y", i),  32'(first_y),  32'(vecs[i].ey));
      check($sformatf("v%0d_first_ch", i), 32'(first_ch), 32'(vecs[i].ec));
      // start and abort during DONE must neither restart nor clear results
      abort = 1'b1;
      start = 1'b1;
      @(posedge clock); #1;
      abort = 1'b0;
      start = 1'b0;
      @(negedge clock);
      check($sformatf("v%0d_idle_busy", i), 32'(busy),     32'd0);
      check($sformatf("v%0d_idle_done", i), 32'(done),     32'd0);
      check($sformatf("v%0d_held_mask", i), 32'(hit_mask), 32'(vecs[i].exp_mask));
      check($sformatf("v%0d_held_fx", i),   32'(first_x),  32'(vecs[i].ex));
      @(posedge clock); #1;
    end

    // Abort at scan cycle 500 with a stray start at cycle 100
    tab[0] = EE ? pix_t'('0) : mk_pix(5, 2, 1'b1, 16'h0008);
    tab[1] = '0;
    tab[2] = '0;
    ch_en  = '1;
    seen_done = 1'b0;
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    for (int n = 1; n <= 500; n++) begin
      start = (n == 100);
      abort = (n == 500);
      @(negedge clock);
      if (done) seen_done = 1'b1;
      if (n == 499) check("pre_abort_hit_any", 32'(hit_any), EE ? 32'd0 : 32'd1);
      @(posedge clock); #1;
    end
    abort = 1'b0;
    @(negedge clock);
    check("abort_no_done",  32'(seen_done), 32'd0);
    check("abort_done",     32'(done),      32'd0);
    check("abort_busy",     32'(busy),      32'd0);
    check("abort_rd_en",    32'(mem.rd_en), 32'd0);
    check("abort_hit_any",  32'(hit_any),   32'd0);
    check("abort_hit_mask", 32'(hit_mask),  32'd0);
    check("abort_first_x",  32'(first_x),   32'd0);
    check("abort_first_y",  32'(first_y),   32'd0);
    @(posedge clock); #1;

    // Restart with start+abort together, empty layers, stray start mid-scan
    tab[0] = '0;
    ch_en  = '1;
    run_frame(1'b1, 1000, lat, rdn);
    check("empty_latency",  32'(lat),      32'd19202);
    check("empty_rd_count", 32'(rdn),      32'd19200);
    check("empty_hit_any",  32'(hit_any),  32'd0);
    check("empty_hit_mask", 32'(hit_mask), 32'd0);
    check("empty_first_x",  32'(first_x),  32'd0);
    check("empty_first_y",  32'(first_y),  32'd0);
    check("empty_first_ch", 32'(first_ch), 32'd0);
    @(posedge clock); #1;

    // Two hits, then asynchronous reset in cycle 6
    tab[0] = mk_pix(3, 0, 1'b1, 16'h0002);
    tab[1] = mk_pix(50, 4, 1'b1, 16'h0010);
    ch_en  = '1;
    start  = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    repeat (5) @(posedge clock);
    @(negedge clock);
    check("c6_hit_mask", 32'(hit_mask),  32'h0002);
    check("c6_hit_any",  32'(hit_any),   32'd1);
    check("c6_first_x",  32'(first_x),   32'd3);
    check("c6_first_y",  32'(first_y),   32'd0);
    check("c6_first_ch", 32'(first_ch),  32'd1);
    check("c6_done",     32'(done),      EE ? 32'd1 : 32'd0);
    check("c6_rd_en",    32'(mem.rd_en), EE ? 32'd0 : 32'd1);
    #1 reset = 1'b1;
    #1;
    check("arst_rd_en",    32'(mem.rd_en), 32'd0);
    check("arst_busy",     32'(busy),      32'd0);
    check("arst_done",     32'(done),      32'd0);
    check("arst_hit_any",  32'(hit_any),   32'd0);
    check("arst_hit_mask", 32'(hit_mask),  32'd0);
    check("arst_first_ch", 32'(first_ch),  32'd0);
    @(negedge clock);
    reset = 1'b0;
    repeat (2) @(posedge clock);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
